// File: rtl/i2c_slave_mem_model_pkg.sv
// pkg_i2c_slave_model
//   Shared types for the I2C slave memory model: byte-level FSM state
//   encoding, ACK/NACK bit levels and R/W bit levels.
//   No ports.
package pkg_i2c_slave_model;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

  localparam logic BIT_ACK  = 1'b0;
  localparam logic BIT_NACK = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Bit counter value that marks the ninth (acknowledge) bit of a byte
  localparam logic [3:0] ACK_SLOT = 4'd8;

endpackage

// File: rtl/i2c_slave_mem_model_bus_sync.sv
// i2c_bus_sync
//   Synchronises raw SCL/SDA into clk_i and derives single-cycle strobes.
//   Ports:
//     clk_i, rst_ni  oversampling clock, async active-low reset
//     scl_i, sda_i   raw bus levels
//     sda_o          synchronised SDA level
//     scl_rise_o     SCL 0->1 strobe
//     scl_fall_o     SCL 1->0 strobe
//     start_o        START strobe (SDA 1->0 while SCL high)
//     stop_o         STOP strobe  (SDA 0->1 while SCL high)
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Idle bus is high, so the chains reset to 1 to avoid a false START/STOP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_mem_model.sv
// i2c_slave_mem_model
//   EEPROM-style I2C slave memory used as a bench model for I2C master tests.
//   Oversamples the bus with clk_i, decodes device address, pointer bytes and
//   data; supports page-wrapped writes, sequential/random reads, repeated
//   START and write protect.
//   Optional feature macro: I2C_MODEL_STRETCH_EN -- hold SCL low for
//   STRETCH_CYCLES clk_i cycles after every acknowledge bit.
//   Ports:
//     clk_i   oversampling clock (>= 8x SCL)
//     rst_ni  async active-low reset
//     scl_io  I2C clock, driven 0 or Z
//     sda_io  I2C data, driven 0 or Z
//     wp_i    write protect: data bytes NACKed and not stored
//     sel_o   device currently addressed
//     ptr_o   memory pointer
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | bus free, waiting for START
// ST_DEV_ADDR | shifting in device address + R/W
// ST_DEV_ACK  | driving ACK for matched device address
// ST_PTR      | shifting in a pointer byte
// ST_PTR_ACK  | driving ACK for a pointer byte
// ST_WR_DATA  | shifting in a write data byte
// ST_WR_ACK   | driving ACK for a stored data byte
// ST_RD_DATA  | driving a read data byte
// ST_RD_ACK   | sampling master ACK/NACK
// ST_IGNORE   | not addressed / NACKed, wait for START or STOP
module i2c_slave_mem_model
  import pkg_i2c_slave_model::*;
#(
  parameter logic [6:0] ADDRESS        = 7'h2A,
  parameter int         ADDR_BYTES     = 2,
  parameter int         MEM_DEPTH      = 65536,
  parameter int         PAGE_SIZE      = 64,
  parameter int         SYNC_STAGES    = 2,
  parameter int         STRETCH_CYCLES = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  inout  wire                          scl_io,
  inout  wire                          sda_io,
  input  logic                         wp_i,
  output logic                         sel_o,
  output logic [$clog2(MEM_DEPTH)-1:0] ptr_o
);

  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam int STRETCH_W = (STRETCH_CYCLES < 1) ? 1 : $clog2(STRETCH_CYCLES + 1);
  localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(PAGE_SIZE - 1);
  localparam logic [MEM_AW-1:0] PTR_ONE   = MEM_AW'(1);

`ifdef I2C_MODEL_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_io),
    .sda_i      (sda_io),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_e               state_q;
  logic [3:0]           bit_cnt_q;
  logic [7:0]           shift_q;
  logic [MEM_AW-1:0]    ptr_q;
  logic [7:0]           ptr_hi_q;
  logic                 byte_idx_q;
  logic                 rw_q;
  logic                 mst_ack_q;
  logic                 wp_lat_q;
  logic                 sel_q;
  logic                 sda_oe_q;
  logic                 scl_oe_q;
  logic [STRETCH_W-1:0] stretch_cnt_q;
  logic [7:0]           mem_q [MEM_DEPTH];

  logic              rise, fall, line_evt;
  logic              last_ptr_byte, in_ack_state, stretch_start, mem_we;
  logic [MEM_AW-1:0] ptr_inc, ptr_page_nxt, ptr_load;
  logic [7:0]        rd_byte, rd_byte_nxt;

  // SCL edges are ignored while we are the ones holding SCL low
  assign rise     = scl_rise & ~scl_oe_q;
  assign fall     = scl_fall & ~scl_oe_q;
  assign line_evt = start_det | stop_det;

  assign last_ptr_byte = (ADDR_BYTES == 1) || byte_idx_q;
  assign ptr_inc       = ptr_q + PTR_ONE;
  assign ptr_page_nxt  = (ptr_q & ~PAGE_MASK) | (ptr_inc & PAGE_MASK);
  assign ptr_load      = (ADDR_BYTES == 1) ? MEM_AW'(shift_q) : MEM_AW'({ptr_hi_q, shift_q});
  assign rd_byte       = mem_q[ptr_q];
  assign rd_byte_nxt   = mem_q[ptr_inc];

  assign in_ack_state = (state_q == ST_DEV_ACK) || (state_q == ST_PTR_ACK) ||
                        (state_q == ST_WR_ACK)  || (state_q == ST_RD_ACK);

  assign mem_we = rise && !line_evt && (state_q == ST_WR_DATA) &&
                  (bit_cnt_q == 4'd7) && !wp_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      ptr_hi_q   <= '0;
      byte_idx_q <= 1'b0;
      rw_q       <= RW_WRITE;
      mst_ack_q  <= BIT_NACK;
      wp_lat_q   <= 1'b0;
      sel_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else if (stop_det) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sel_q     <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else if (start_det) begin
      state_q   <= ST_DEV_ADDR;
      bit_cnt_q <= '0;
      sel_q     <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else if (rise) begin
      case (state_q)
        ST_DEV_ADDR, ST_PTR, ST_WR_DATA: begin
          if (bit_cnt_q != ACK_SLOT) begin
            shift_q   <= {shift_q[6:0], sda_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
          if (state_q == ST_WR_DATA && bit_cnt_q == 4'd7) begin
            wp_lat_q <= wp_i;
            if (!wp_i) ptr_q <= ptr_page_nxt;
          end
        end
        ST_RD_DATA: begin
          if (bit_cnt_q != ACK_SLOT) bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        ST_RD_ACK: mst_ack_q <= sda_s;
        default: ;
      endcase
    end else if (fall) begin
      case (state_q)
        ST_DEV_ADDR: begin
          if (bit_cnt_q == ACK_SLOT) begin
            if (shift_q[7:1] == ADDRESS) begin
              state_q  <= ST_DEV_ACK;
              sda_oe_q <= 1'b1;
              sel_q    <= 1'b1;
              rw_q     <= shift_q[0];
            end else begin
              state_q <= ST_IGNORE;
            end
          end
        end
        ST_DEV_ACK: begin
          bit_cnt_q <= '0;
          if (rw_q == RW_READ) begin
            state_q  <= ST_RD_DATA;
            shift_q  <= rd_byte;
            sda_oe_q <= ~rd_byte[7];
          end else begin
            state_q    <= ST_PTR;
            sda_oe_q   <= 1'b0;
            byte_idx_q <= 1'b0;
          end
        end
        ST_PTR: begin
          if (bit_cnt_q == ACK_SLOT) begin
            state_q  <= ST_PTR_ACK;
            sda_oe_q <= 1'b1;
            if (last_ptr_byte) ptr_q <= ptr_load;
            else               ptr_hi_q <= shift_q;
          end
        end
        ST_PTR_ACK: begin
          sda_oe_q  <= 1'b0;
          bit_cnt_q <= '0;
          if (last_ptr_byte) begin
            state_q <= ST_WR_DATA;
          end else begin
            state_q    <= ST_PTR;
            byte_idx_q <= 1'b1;
          end
        end
        ST_WR_DATA: begin
          if (bit_cnt_q == ACK_SLOT) begin
            if (wp_lat_q) begin
              state_q <= ST_IGNORE;
              sel_q   <= 1'b0;
            end else begin
              state_q  <= ST_WR_ACK;
              sda_oe_q <= 1'b1;
            end
          end
        end
        ST_WR_ACK: begin
          state_q   <= ST_WR_DATA;
          sda_oe_q  <= 1'b0;
          bit_cnt_q <= '0;
        end
        ST_RD_DATA: begin
          if (bit_cnt_q == ACK_SLOT) begin
            state_q  <= ST_RD_ACK;
            sda_oe_q <= 1'b0;
          end else if (bit_cnt_q != 4'd0) begin
            shift_q  <= {shift_q[6:0], 1'b0};
            sda_oe_q <= ~shift_q[6];
          end
        end
        ST_RD_ACK: begin
          bit_cnt_q <= '0;
          if (mst_ack_q == BIT_ACK) begin
            state_q  <= ST_RD_DATA;
            ptr_q    <= ptr_inc;
            shift_q  <= rd_byte_nxt;
            sda_oe_q <= ~rd_byte_nxt[7];
          end else begin
            state_q  <= ST_IGNORE;
            sel_q    <= 1'b0;
            sda_oe_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: 8'hFF};
    end else if (mem_we) begin
      mem_q[ptr_q] <= {shift_q[6:0], sda_s};
    end
  end

  // Clock stretch: down-counter loaded on the falling edge that ends an ACK bit
  assign stretch_start = STRETCH_EN && (STRETCH_CYCLES > 0) && fall && !line_evt && in_ack_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_oe_q      <= 1'b0;
      stretch_cnt_q <= '0;
    end else if (line_evt) begin
      scl_oe_q <= 1'b0;
    end else if (stretch_start) begin
      scl_oe_q      <= 1'b1;
      stretch_cnt_q <= STRETCH_W'(STRETCH_CYCLES);
    end else if (scl_oe_q) begin
      if (stretch_cnt_q == STRETCH_W'(1)) scl_oe_q <= 1'b0;
      else                                stretch_cnt_q <= stretch_cnt_q - STRETCH_W'(1);
    end
  end

  // A START/STOP releases SDA in the cycle it is detected, ahead of the register
  assign sda_io = (sda_oe_q && !line_evt) ? 1'b0 : 1'bz;
  assign scl_io = scl_oe_q ? 1'b0 : 1'bz;

  assign sel_o = sel_q;
  assign ptr_o = ptr_q;

endmodule

// File: tb/tb_i2c_slave_mem_model.sv
module tb_i2c_slave_mem_model;

  localparam int         Q     = 5;      // quarter SCL period in clk_i cycles
  localparam logic [6:0] DEV   = 7'h2A;
  localparam int         PAGE  = 64;
  localparam int         DEPTH = 65536;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wp_i;
  logic        m_scl_oe;
  logic        m_sda_oe;
  logic        sel_o;
  logic [15:0] ptr_o;
  wire         scl_io;
  wire         sda_io;

  int total = 0;
  int bad   = 0;

  pullup (scl_io);
  pullup (sda_io);
  assign scl_io = m_scl_oe ? 1'b0 : 1'bz;
  assign sda_io = m_sda_oe ? 1'b0 : 1'bz;

  always #5 clk_i = ~clk_i;

  i2c_slave_mem_model dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .scl_io (scl_io),
    .sda_io (sda_io),
    .wp_i   (wp_i),
    .sel_o  (sel_o),
    .ptr_o  (ptr_o)
  );

  // Reference model: byte array plus pointer, updated from the protocol rules
  logic [7:0]  ref_mem [DEPTH];
  logic [15:0] ref_ptr;
  logic [7:0]  wq [$];

  // Watches that the slave never pulls SDA low while unaddressed
  logic watch = 1'b0;
  int   viol  = 0;
  always @(posedge clk_i) if (watch && !m_sda_oe && sda_io !== 1'b1) viol++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
    ref_ptr = '0;
  endtask

  function automatic logic [15:0] page_next(input logic [15:0] p);
    int base, off;
    base = int'(p) - (int'(p) % PAGE);
    off  = ((int'(p) % PAGE) + 1) % PAGE;
    return 16'(base + off);
  endfunction

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic bus_start();
    clk_wait(Q); m_sda_oe = 1'b0;
    clk_wait(Q); m_scl_oe = 1'b0;
    clk_wait(Q); m_sda_oe = 1'b1;
    clk_wait(Q); m_scl_oe = 1'b1;
  endtask

  task automatic bus_stop();
    clk_wait(Q); m_sda_oe = 1'b1;
    clk_wait(Q); m_scl_oe = 1'b0;
    clk_wait(Q); m_sda_oe = 1'b0;
    clk_wait(Q);
  endtask

  // One bit: set SDA while SCL low, sample mid-high, end with SCL pulled low
  task automatic bit_slot(input logic b_out, output logic b_in);
    clk_wait(Q); m_sda_oe = ~b_out;
    clk_wait(Q); m_scl_oe = 1'b0;
    clk_wait(Q); b_in = sda_io;
    clk_wait(Q); m_scl_oe = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_slot(b[i], d);
    bit_slot(1'b1, d);
    ack = ~d;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b1, d);
      b[i] = d;
    end
    bit_slot(~mack, d);
  endtask

  task automatic send_addr_ptr(input logic [15:0] addr, output int all_ack);
    logic a;
    all_ack = 1;
    bus_start();
    send_byte({DEV, 1'b0}, a); if (!a) all_ack = 0;
    send_byte(addr[15:8], a);  if (!a) all_ack = 0;
    send_byte(addr[7:0], a);   if (!a) all_ack = 0;
    ref_ptr = addr;
  endtask

  task automatic write_txn(input string tag, input logic [15:0] addr);
    logic a;
    int   ok;
    send_addr_ptr(addr, ok);
    check({tag, " hdr_ack"}, ok, 1);
    check({tag, " sel_on"}, sel_o, 1'b1);
    foreach (wq[k]) begin
      send_byte(wq[k], a);
      check({tag, " data_ack"}, a, !wp_i);
      if (wp_i) break;
      ref_mem[ref_ptr] = wq[k];
      ref_ptr = page_next(ref_ptr);
    end
    bus_stop();
    check({tag, " ptr"}, ptr_o, ref_ptr);
    check({tag, " sel_off"}, sel_o, 1'b0);
  endtask

  task automatic read_txn(input string tag, input logic [15:0] addr, input int n);
    logic       a;
    logic [7:0] d;
    int         ok;
    send_addr_ptr(addr, ok);
    bus_start();
    send_byte({DEV, 1'b1}, a); if (!a) ok = 0;
    check({tag, " hdr_ack"}, ok, 1);
    check({tag, " sel_on"}, sel_o, 1'b1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k < n - 1, d);
      check({tag, " rdata"}, d, ref_mem[ref_ptr]);
      if (k < n - 1) ref_ptr = ref_ptr + 16'd1;
    end
    clk_wait(Q);
    check({tag, " sda_rel"}, sda_io, 1'b1);
    check({tag, " sel_nack"}, sel_o, 1'b0);
    bus_stop();
    check({tag, " ptr"}, ptr_o, ref_ptr);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         ok;
    logic [15:0] ra;
    int          rn;

    rst_ni   = 1'b0;
    wp_i     = 1'b0;
    m_scl_oe = 1'b0;
    m_sda_oe = 1'b0;
    model_reset();
    clk_wait(3);
    check("reset sel", sel_o, 1'b0);
    check("reset ptr", ptr_o, 16'h0000);
    check("reset sda", sda_io, 1'b1);
    check("reset scl", scl_io, 1'b1);
    rst_ni = 1'b1;
    clk_wait(5);

    // 1: two-byte write at 0x0010
    wq = '{8'hA5, 8'h5A};
    write_txn("t1", 16'h0010);

    // 2: random read of what was written, master NACKs the last byte
    read_txn("t2", 16'h0010, 2);
    check("t2 first byte", ref_mem[16'h0010], 8'hA5);

    // 3: page wrap at 0x003F
    wq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    write_txn("t3", 16'h003F);
    read_txn("t3 rd_hi", 16'h003F, 2);
    read_txn("t3 rd_lo", 16'h0000, 2);
    check("t3 0x40 untouched", ref_mem[16'h0040], 8'hFF);

    // 4: wrong device address
    watch = 1'b1;
    bus_start();
    send_byte(8'h56, a);
    check("t4 addr_nack", a, 1'b0);
    check("t4 sel", sel_o, 1'b0);
    send_byte(8'h00, a);
    check("t4 byte_nack", a, 1'b0);
    bus_stop();
    watch = 1'b0;
    check("t4 no_drive", viol, 0);

    // 5: write protect
    wp_i = 1'b1;
    wq = '{8'h11};
    write_txn("t5", 16'h0020);
    wp_i = 1'b0;
    read_txn("t5 rd", 16'h0020, 1);

    // 6: read across the top of memory, reset in the middle of the third byte
    send_addr_ptr(16'hFFFF, ok);
    bus_start();
    send_byte({DEV, 1'b1}, a); if (!a) ok = 0;
    check("t6 hdr_ack", ok, 1);
    recv_byte(1'b1, d);
    check("t6 rdata0", d, ref_mem[ref_ptr]);
    ref_ptr = ref_ptr + 16'd1;
    recv_byte(1'b1, d);
    check("t6 rdata1", d, ref_mem[ref_ptr]);
    ref_ptr = ref_ptr + 16'd1;
    for (int i = 0; i < 3; i++) bit_slot(1'b1, a);
    check("t6 ptr_mid", ptr_o, ref_ptr);
    rst_ni   = 1'b0;
    m_scl_oe = 1'b0;
    m_sda_oe = 1'b0;
    #1;
    check("t6 rst sda", sda_io, 1'b1);
    check("t6 rst scl", scl_io, 1'b1);
    check("t6 rst ptr", ptr_o, 16'h0000);
    check("t6 rst sel", sel_o, 1'b0);
    model_reset();
    clk_wait(3);
    rst_ni = 1'b1;
    clk_wait(5);

    // Random page writes followed by sequential read-back
    for (int it = 0; it < 4; it++) begin
      ra = 16'($urandom);
      rn = $urandom_range(1, 5);
      wq = {};
      for (int k = 0; k < rn; k++) wq.push_back(8'($urandom));
      write_txn("rnd wr", ra);
      read_txn("rnd rd", ra, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
